// File: rtl/wb_slave_mem_pkg.sv
// Shared definitions for the Wishbone slave memory.
//   CTI_* / BTE_* : cycle-type and burst-type codes seen on cti_i / bte_i
//   wb_mem_st_t   : controller state encoding
//   wb_next_adr   : next word index of an incrementing burst (linear or wrap-N)
package wb_slave_mem_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } wb_mem_st_t;

    // Linear bursts may step past the top of memory; the caller compares the
    // full-width result against DEPTH. Wrap bursts only rotate the low bits.
    function automatic logic [31:0] wb_next_adr(input logic [31:0] idx, input logic [1:0] bte);
        logic [31:0] mask;
        case (bte)
            BTE_WRAP4:  mask = 32'd3;
            BTE_WRAP8:  mask = 32'd7;
            BTE_WRAP16: mask = 32'd15;
            default:    mask = 32'd0;
        endcase
        if (mask == 32'd0)
            wb_next_adr = idx + 32'd1;
        else
            wb_next_adr = (idx & ~mask) | ((idx + 32'd1) & mask);
    endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 bus bundle between one master and the slave memory.
//   master -> slave : adr_i, cyc_i, stb_i, we_i, sel_i, cti_i, bte_i, dat_i
//   slave -> master : ack_o, err_o, rty_o, dat_o
interface wb_slave_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr_i;
    logic            cyc_i;
    logic            stb_i;
    logic            we_i;
    logic [DW/8-1:0] sel_i;
    logic [2:0]      cti_i;
    logic [1:0]      bte_i;
    logic [DW-1:0]   dat_i;
    logic            ack_o;
    logic            err_o;
    logic            rty_o;
    logic [DW-1:0]   dat_o;

    modport slave (
        input  adr_i, cyc_i, stb_i, we_i, sel_i, cti_i, bte_i, dat_i,
        output ack_o, err_o, rty_o, dat_o
    );

    modport master (
        output adr_i, cyc_i, stb_i, we_i, sel_i, cti_i, bte_i, dat_i,
        input  ack_o, err_o, rty_o, dat_o
    );
endinterface

// File: rtl/wb_slave_mem_array.sv
// DEPTH x DW storage with per-byte write enables and an asynchronous read port.
// Contents are deliberately not reset so data survives a bus reset.
//   clk     : write clock
//   we      : write strobe, be : byte-lane enables
//   wr_idx  : write word index, wr_data : write data
//   rd_idx  : read word index, rd_data : combinational read data
module wb_slave_mem_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DW/8-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DW-1:0]            rd_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (be[b])
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/wb_slave_mem.sv
// Parametrised Wishbone B4 slave memory: byte-lane writes, programmable wait
// states, incrementing/wrapping registered-feedback bursts, error response for
// out-of-range accesses.
//   clk : bus clock, rst : asynchronous active-low reset
//   wb  : Wishbone slave port (see wb_slave_mem_if)
//
// state   | meaning
// --------+--------------------------------------
// ST_IDLE | no transfer in progress
// ST_WAIT | wait-state counter running
// ST_ACK  | ack_o high, beat completes at next edge
// ST_ERR  | err_o high for exactly one cycle
module wb_slave_mem
    import wb_slave_mem_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic          clk,
    input logic          rst,
    wb_slave_mem_if.slave wb
);
    localparam int SW = DW / 8;
    localparam int SB = $clog2(SW);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW:0] ADR_LIMIT = (AW+1)'(DEPTH * SW);

    wb_mem_st_t    st;
    logic [1:0]    cnt;
    logic [IW-1:0] addr_q;
    logic          ack_q;
    logic          err_q;
    logic [DW-1:0] dat_q;

    logic          req;
    logic          req_oor;
    logic [IW-1:0] req_idx;
    logic [31:0]   nxt_full;
    logic [IW-1:0] nxt_idx;
    logic          nxt_oor;
    logic          mem_we;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_data;

    always_comb begin
        req      = wb.cyc_i & wb.stb_i;
        req_idx  = wb.adr_i[SB +: IW];
        // Full-width compare so aliased upper address bits also raise an error.
        req_oor  = {1'b0, wb.adr_i} >= ADR_LIMIT;
        nxt_full = wb_next_adr(32'(addr_q), wb.bte_i);
        nxt_idx  = nxt_full[IW-1:0];
        nxt_oor  = (wb.bte_i == BTE_LINEAR) && (nxt_full >= 32'(DEPTH));
        mem_we   = (st == ST_ACK) && req && wb.we_i;
        // Read address follows whichever word the next ACK will present.
        case (st)
            ST_IDLE: rd_idx = req_idx;
            ST_ACK:  rd_idx = nxt_idx;
            default: rd_idx = addr_q;
        endcase
    end

    wb_slave_mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .be      (wb.sel_i),
        .wr_idx  (addr_q),
        .wr_data (wb.dat_i),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= req_idx;
                        if (req_oor) begin
                            st    <= ST_ERR;
                            err_q <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            st    <= ST_ACK;
                            ack_q <= 1'b1;
                            dat_q <= wb.we_i ? '0 : rd_data;
                        end else begin
                            st  <= ST_WAIT;
                            cnt <= 2'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb.cyc_i) begin
                        st <= ST_IDLE;
                    end else if (cnt == 2'd0) begin
                        st    <= ST_ACK;
                        ack_q <= 1'b1;
                        dat_q <= wb.we_i ? '0 : rd_data;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    ack_q <= 1'b0;
                    dat_q <= '0;
                    if (req && wb.cti_i == CTI_INCR) begin
                        if (nxt_oor) begin
                            st    <= ST_ERR;
                            err_q <= 1'b1;
                        end else begin
                            addr_q <= nxt_idx;
                            if (WAIT_STATES == 0) begin
                                ack_q <= 1'b1;
                                dat_q <= wb.we_i ? '0 : rd_data;
                            end else begin
                                st  <= ST_WAIT;
                                cnt <= 2'(WAIT_STATES - 1);
                            end
                        end
                    end else begin
                        // End of classic/last beat, or master abort.
                        st <= ST_IDLE;
                    end
                end
                default: begin
                    err_q <= 1'b0;
                    st    <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
    assign wb.rty_o = 1'b0;
    assign wb.dat_o = dat_q;
endmodule
